// File: rtl/t03_ssrecv_if.sv
// Seven-segment receiver bus bundle: multiplexed digit strobe/segments in,
// recovered digits, update events and error reporting out.
interface t03_ssrecv_if #(
    parameter int NUM_DIGITS = 8
);
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic [7:0]              seg_in;
    logic [4*NUM_DIGITS-1:0] digit_val;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    upd_valid;
    logic [3:0]              upd_idx;
    logic [3:0]              upd_nibble;
    logic                    err;
    logic [7:0]              err_count;

    modport master (
        output dig_sel, seg_in,
        input  digit_val, digit_valid, upd_valid, upd_idx, upd_nibble, err, err_count
    );

    modport slave (
        input  dig_sel, seg_in,
        output digit_val, digit_valid, upd_valid, upd_idx, upd_nibble, err, err_count
    );
endinterface

// File: rtl/t03_ssrecv.sv
// Seven-segment receiver: qualifies each {dig_sel, seg_in} sample for stability,
// reverse-decodes it to a hex nibble and stores it per digit; bad patterns are counted.
module t03_ssrecv #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    t03_ssrecv_if.slave   bus
);
    localparam int SW = NUM_DIGITS + 8;
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic                    srst;
    logic [SW-1:0]           s_new;
    logic [SW-1:0]           s_q;
    logic [CW-1:0]           cnt;
    logic                    qual;

    logic [NUM_DIGITS-1:0]   sel;
    logic [7:0]              seg;
    logic                    any_sel;
    logic                    multi;
    logic                    blank;
    logic                    hit;
    logic [3:0]              nib;
    logic [3:0]              k;
    logic                    do_upd;
    logic                    do_err;

    logic [4*NUM_DIGITS-1:0] dval_q;
    logic [NUM_DIGITS-1:0]   dvld_q;
    logic                    upd_q;
    logic [3:0]              idx_q;
    logic [3:0]              nib_q;
    logic                    err_q;
    logic [7:0]              ecnt_q;

    assign srst  = rst | clear;
    assign s_new = {bus.dig_sel, bus.seg_in};

    // qual is registered so the decode uses s_q one edge after cnt saturates,
    // giving outputs exactly STABLE_CYCLES edges after the input change.
    always_ff @(posedge clk) begin
        if (srst) begin
            s_q  <= '0;
            cnt  <= '0;
            qual <= 1'b0;
        end else begin
            s_q <= s_new;
            if (s_new == s_q) begin
                if (cnt != CW'(STABLE_CYCLES))
                    cnt <= cnt + CW'(1);
            end else begin
                cnt <= CW'(1);
            end
            qual <= (s_new == s_q) && (cnt == CW'(STABLE_CYCLES - 1));
        end
    end

    always_comb begin
        sel     = s_q[SW-1:8];
        seg     = s_q[7:0];
        any_sel = |sel;
        multi   = |(sel & (sel - NUM_DIGITS'(1)));
        k       = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i])
                k = 4'(i);
        end
        blank = (seg == 8'h00);
        hit   = 1'b1;
        nib   = '0;
        case (seg)
            8'h3F: nib = 4'h0;
            8'h06: nib = 4'h1;
            8'h5B: nib = 4'h2;
            8'h4F: nib = 4'h3;
            8'h66: nib = 4'h4;
            8'h6D: nib = 4'h5;
            8'h7D: nib = 4'h6;
            8'h07: nib = 4'h7;
            8'h7F: nib = 4'h8;
            8'h67: nib = 4'h9;
            8'h77: nib = 4'hA;
            8'h7C: nib = 4'hB;
            8'h39: nib = 4'hC;
            8'h5E: nib = 4'hD;
            8'h79: nib = 4'hE;
            8'h71: nib = 4'hF;
            default: hit = 1'b0;
        endcase
        do_upd = qual & any_sel & ~multi & (blank | hit);
        do_err = qual & any_sel & (multi | (~blank & ~hit));
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            dval_q <= '0;
            dvld_q <= '0;
            upd_q  <= 1'b0;
            idx_q  <= '0;
            nib_q  <= '0;
            err_q  <= 1'b0;
            ecnt_q <= '0;
        end else begin
            upd_q <= do_upd;
            err_q <= do_err;
            if (do_upd) begin
                idx_q             <= k;
                nib_q             <= blank ? 4'h0 : nib;
                dval_q[4*k +: 4]  <= blank ? 4'h0 : nib;
                dvld_q[k]         <= ~blank;
            end
            if (do_err && ecnt_q != 8'hFF)
                ecnt_q <= ecnt_q + 8'd1;
        end
    end

    assign bus.digit_val   = dval_q;
    assign bus.digit_valid = dvld_q;
    assign bus.upd_valid   = upd_q;
    assign bus.upd_idx     = idx_q;
    assign bus.upd_nibble  = nib_q;
    assign bus.err         = err_q;
    assign bus.err_count   = ecnt_q;
endmodule

// File: tb/tb_t03_ssrecv.sv
// Randomised + directed bench for t03_ssrecv: a run-length reference model queues
// expected events, an independent monitor pops and compares them as the DUT pulses.
module tb_t03_ssrecv;
    localparam int ND = 8;
    localparam int ST = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    int   ecount = 0;
    int   nchecks = 0;
    int   nfail = 0;

    t03_ssrecv_if #(.NUM_DIGITS(ND)) bus ();

    t03_ssrecv #(.NUM_DIGITS(ND), .STABLE_CYCLES(ST)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecount <= ecount + 1;

    typedef struct {
        int              cyc;
        bit              is_err;
        logic [3:0]      idx;
        logic [3:0]      nib;
        logic [7:0]      ecnt;
        logic [4*ND-1:0] dval;
        logic [ND-1:0]   dvld;
    } exp_t;

    exp_t sb[$];

    logic [7:0] tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h67, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    // reference model state
    logic [ND+7:0]   prev = '0;
    int              run = 0;
    bit              pend = 0;
    logic [ND+7:0]   pend_s = '0;
    logic [4*ND-1:0] m_val = '0;
    logic [ND-1:0]   m_vld = '0;
    logic [7:0]      m_ecnt = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%0h expected=%0h (edge %0d)", nm, act, exp, ecount);
        end
    endtask

    task automatic push_evt(input int cyc, input bit is_err, input int k, input int n);
        exp_t e;
        e.cyc    = cyc;
        e.is_err = is_err;
        e.idx    = 4'(k);
        e.nib    = 4'(n);
        e.ecnt   = m_ecnt;
        e.dval   = m_val;
        e.dvld   = m_vld;
        sb.push_back(e);
    endtask

    task automatic apply(input logic [ND+7:0] s, input int cyc);
        logic [ND-1:0] sel;
        logic [7:0]    seg;
        int            k;
        int            n;
        sel = s[ND+7:8];
        seg = s[7:0];
        if ($countones(sel) == 0) return;
        if ($countones(sel) > 1) begin
            if (m_ecnt != 8'hFF) m_ecnt++;
            push_evt(cyc, 1, 0, 0);
            return;
        end
        k = 0;
        for (int i = 0; i < ND; i++) if (sel[i]) k = i;
        n = -1;
        for (int i = 0; i < 16; i++) if (tbl[i] == seg) n = i;
        if (seg == 8'h00) begin
            m_vld[k] = 1'b0;
            m_val[4*k +: 4] = 4'h0;
            push_evt(cyc, 0, k, 0);
        end else if (n < 0) begin
            if (m_ecnt != 8'hFF) m_ecnt++;
            push_evt(cyc, 1, 0, 0);
        end else begin
            m_vld[k] = 1'b1;
            m_val[4*k +: 4] = 4'(n);
            push_evt(cyc, 0, k, n);
        end
    endtask

    // Drive one cycle of bus inputs and advance the model to the coming edge.
    task automatic drive(input logic [ND-1:0] sel, input logic [7:0] seg, input bit r, input bit c);
        logic [ND+7:0] s;
        int            e;
        @(negedge clk);
        bus.dig_sel = sel;
        bus.seg_in  = seg;
        rst         = r;
        clear       = c;
        e = ecount + 1;
        if (r || c) begin
            pend   = 0;
            prev   = '0;
            run    = 0;
            m_val  = '0;
            m_vld  = '0;
            m_ecnt = '0;
        end else begin
            if (pend) apply(pend_s, e);
            pend = 0;
            s = {sel, seg};
            if (s == prev) begin
                if (run < ST) begin
                    run++;
                    if (run == ST) begin
                        pend   = 1;
                        pend_s = s;
                    end
                end
            end else begin
                run = 1;
            end
            prev = s;
        end
    endtask

    task automatic hold(input logic [ND-1:0] sel, input logic [7:0] seg, input int n);
        for (int i = 0; i < n; i++) drive(sel, seg, 0, 0);
    endtask

    task automatic chk_zero(input string nm);
        @(posedge clk);
        #2;
        chk({nm, "_digit_val"},   bus.digit_val,   '0);
        chk({nm, "_digit_valid"}, bus.digit_valid, '0);
        chk({nm, "_upd_valid"},   bus.upd_valid,   '0);
        chk({nm, "_upd_idx"},     bus.upd_idx,     '0);
        chk({nm, "_upd_nibble"},  bus.upd_nibble,  '0);
        chk({nm, "_err"},         bus.err,         '0);
        chk({nm, "_err_count"},   bus.err_count,   '0);
    endtask

    // monitor: compares every DUT pulse against the queued expectation
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (bus.upd_valid && bus.err)
            chk("pulse_exclusive", {bus.upd_valid, bus.err}, 2'b10);
        if (bus.upd_valid || bus.err) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", {bus.upd_valid, bus.err}, 2'b00);
            end else begin
                e = sb.pop_front();
                chk("evt_cycle", ecount, e.cyc);
                chk("evt_kind", {bus.upd_valid, bus.err}, e.is_err ? 2'b01 : 2'b10);
                if (!e.is_err) begin
                    chk("upd_idx", bus.upd_idx, e.idx);
                    chk("upd_nibble", bus.upd_nibble, e.nib);
                end
                chk("err_count", bus.err_count, e.ecnt);
                chk("digit_val", bus.digit_val, e.dval);
                chk("digit_valid", bus.digit_valid, e.dvld);
            end
        end else if (sb.size() > 0 && sb[0].cyc <= ecount) begin
            e = sb.pop_front();
            chk("missing_event", {bus.upd_valid, bus.err}, e.is_err ? 2'b01 : 2'b10);
        end
    end

    initial begin
        logic [ND-1:0] sel;
        logic [7:0]    seg;
        int            r;

        bus.dig_sel = '0;
        bus.seg_in  = '0;
        drive('0, 8'h00, 1, 0);
        drive('0, 8'h00, 1, 0);
        chk_zero("reset");

        hold(8'h01, 8'h5B, 6);
        hold(8'h04, 8'h06, 3);
        hold(8'h04, 8'h7D, 6);
        hold(8'h04, 8'h80, 6);
        hold(8'h04, 8'h2A, 6);
        hold(8'h08, 8'h77, 6);
        hold(8'h08, 8'h00, 6);

        for (int i = 0; i < 300; i++)
            hold(8'h01, (i % 2 == 1) ? 8'h80 : 8'h2A, 5);
        @(posedge clk);
        #2;
        chk("err_count_saturated", bus.err_count, 8'hFF);
        drive(8'h01, 8'h2A, 0, 1);
        chk_zero("clear");

        hold(8'h03, 8'h3F, 6);
        hold(8'h01, 8'h06, 2);
        drive(8'h01, 8'h06, 1, 0);
        hold(8'h01, 8'h06, 6);

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      sel = ND'(1) << $urandom_range(0, ND - 1);
            else if (r < 80) sel = '0;
            else begin
                sel = ND'($urandom);
                while ($countones(sel) < 2) sel = ND'($urandom);
            end
            r = $urandom_range(0, 99);
            if (r < 60)      seg = tbl[$urandom_range(0, 15)];
            else if (r < 75) seg = 8'h00;
            else             seg = 8'($urandom);
            if ($urandom_range(0, 49) == 0)
                drive(sel, seg, $urandom_range(0, 1) == 1, 1);
            hold(sel, seg, $urandom_range(1, 7));
        end

        hold('0, 8'h00, 8);
        @(posedge clk);
        #2;
        chk("queue_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
